// File: rtl/m_upsample_if.sv
// ----------------------------------------------------------------------------
// m_upsample_if
// Sample-path bundle for the fractional interpolator: the input AXI-Stream
// (baseband side) and the output AXI-Stream (DAC-rate side) in one interface.
//
// Signals
//   i_tdata  [WIDTH] input sample          i_tlast  input end of packet
//   i_tvalid         input valid           i_tready input ready (from DUT)
//   o_tdata  [WIDTH] output sample         o_tlast  output end of packet
//   o_tvalid         output valid          o_tready output ready (to DUT)
//
// Modports
//   slave  : the interpolator's view (consumes i_*, produces o_*)
//   master : the surrounding source/sink view
// ----------------------------------------------------------------------------
interface m_upsample_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] i_tdata;
    logic             i_tlast;
    logic             i_tvalid;
    logic             i_tready;
    logic [WIDTH-1:0] o_tdata;
    logic             o_tlast;
    logic             o_tvalid;
    logic             o_tready;

    modport slave (
        input  i_tdata,
        input  i_tlast,
        input  i_tvalid,
        output i_tready,
        output o_tdata,
        output o_tlast,
        output o_tvalid,
        input  o_tready
    );

    modport master (
        output i_tdata,
        output i_tlast,
        output i_tvalid,
        input  i_tready,
        input  o_tdata,
        input  o_tlast,
        input  o_tvalid,
        output o_tready
    );
endinterface

// File: rtl/m_upsample.sv
// ----------------------------------------------------------------------------
// m_upsample
// Fractional interpolator on the AXI-Stream sample path. Raises the sample
// rate by n1 + n3/n2: every accepted input sample is emitted n1 times, plus
// one extra time whenever the fractional accumulator overflows. In
// zero-stuff mode the repeated copies carry zero data so a downstream FIR
// can perform the actual interpolation.
//
// Ports
//   clk         system clock
//   rst         synchronous active-high reset
//   n1  [16]    integer repeat count (0 = pass-through)
//   n2  [16]    fractional denominator (0 = no fractional part)
//   n3  [16]    fractional numerator (must be < n2)
//   zero_stuff  1: repeat copies are zero, 0: repeat copies hold the sample
//   io_bus      input and output AXI-Stream (m_upsample_if.slave)
//
// Storage is a single holding register (data, last, remaining count, first
// flag). The two-state FSM is EMPTY (nothing held) or EMIT (o_tvalid high).
// A new sample is accepted on the same edge the final repeat of the held
// sample is taken, so a steady stream runs without bubbles.
// ----------------------------------------------------------------------------
module m_upsample #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [15:0]        n1,
    input  logic [15:0]        n2,
    input  logic [15:0]        n3,
    input  logic               zero_stuff,
    m_upsample_if.slave        io_bus
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_EMIT  = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Holding register
    logic [WIDTH-1:0] r_data;
    logic             r_last;
    logic [16:0]      r_remaining;   // up to 65535 + 1 extra repeat
    logic             r_first;
    logic [15:0]      r_acc;

    logic             w_full;
    logic             w_beat;
    logic             w_final;
    logic             w_in_ready;
    logic             w_accept;
    logic [16:0]      w_sum;
    logic [15:0]      w_sum_wrap;
    logic             w_frac_on;
    logic             w_ext;
    logic             w_misconfig;
    logic [16:0]      w_reps;
    logic [15:0]      w_acc_next;
    logic             w_pass;
    logic [WIDTH-1:0] w_odata;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    assign w_full     = (r_state == ST_EMIT);
    assign w_beat     = w_full & io_bus.o_tready;
    assign w_final    = (r_remaining == 17'd1);
    // Ready when empty, or when the final repeat leaves on this edge.
    assign w_in_ready = ~rst & (~w_full | (w_beat & w_final));
    assign w_accept   = io_bus.i_tvalid & w_in_ready;

    // ------------------------------------------------------------------
    // Fractional accumulator. The sum is formed in 17 bits so the overflow
    // comparison against n2 is exact; after subtracting n2 the result is
    // below n2 under legal settings, so 16 bits hold it.
    // ------------------------------------------------------------------
    assign w_sum       = {1'b0, r_acc} + {1'b0, n3};
    assign w_sum_wrap  = w_sum[15:0] - n2;
    assign w_frac_on   = (n2 != 16'd0);
    assign w_ext       = w_frac_on & (w_sum >= {1'b0, n2});
    // With n3 >= n2 every sample overflows; the accumulator is pinned at
    // zero so it cannot drift into values no legal setting produces.
    assign w_misconfig = w_frac_on & (n3 >= n2);

    always_comb begin
        w_reps     = 17'd1;
        w_acc_next = r_acc;
        if (n1 != 16'd0) begin
            if (w_ext) begin
                w_reps     = {1'b0, n1} + 17'd1;
                w_acc_next = w_misconfig ? 16'd0 : w_sum_wrap;
            end else begin
                w_reps     = {1'b0, n1};
                w_acc_next = w_sum[15:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register and next-state logic
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_next = ST_EMIT;
                end
            end
            ST_EMIT: begin
                // Back-to-back accept on the final beat keeps us in EMIT.
                if (w_beat && w_final && !w_accept) begin
                    w_state_next = ST_EMPTY;
                end
            end
            default: w_state_next = ST_EMPTY;
        endcase
    end

    // ------------------------------------------------------------------
    // Holding register and accumulator. An accept takes priority over the
    // beat bookkeeping of the sample being retired on the same edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data      <= '0;
            r_last      <= 1'b0;
            r_remaining <= 17'd0;
            r_first     <= 1'b0;
            r_acc       <= 16'd0;
        end else if (w_accept) begin
            r_data      <= io_bus.i_tdata;
            r_last      <= io_bus.i_tlast;
            r_remaining <= w_reps;
            r_first     <= 1'b1;
            r_acc       <= w_acc_next;
        end else if (w_beat) begin
            r_remaining <= r_remaining - 17'd1;
            r_first     <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Output data: the first copy always carries the sample; later copies
    // are masked to zero in zero-stuff mode.
    // ------------------------------------------------------------------
    assign w_pass = r_first | ~zero_stuff;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_odata
            assign w_odata[gi] = r_data[gi] & w_pass;
        end
    endgenerate

    assign io_bus.i_tready = w_in_ready;
    assign io_bus.o_tvalid = w_full;
    assign io_bus.o_tdata  = w_odata;
    // tlast marks only the final copy of a packet-ending sample.
    assign io_bus.o_tlast  = r_last & w_final;

endmodule

// File: tb/tb_m_upsample.sv
// ----------------------------------------------------------------------------
// tb_m_upsample
// Directed bench for m_upsample. Each sent sample pushes its expected output
// beats (data, last, final-copy flag) to a scoreboard; a negedge monitor pops
// and compares them as the DUT emits beats, and also checks i_tready,
// one-cycle latency and stall stability.
// ----------------------------------------------------------------------------
module tb_m_upsample;

    localparam int WIDTH = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] n1 = 16'd0;
    logic [15:0] n2 = 16'd0;
    logic [15:0] n3 = 16'd0;
    logic        zero_stuff = 1'b0;

    logic        rdy_main = 1'b1;
    logic        rdy_rnd  = 1'b1;
    logic        rnd_mode = 1'b0;

    int n_cmp = 0;
    int n_err = 0;
    int beats = 0;

    typedef struct packed {
        logic [31:0] d;
        logic        l;
        logic        f;
    } exp_t;

    exp_t sb[$];

    m_upsample_if #(.WIDTH(WIDTH)) bus ();

    assign bus.o_tready = rnd_mode ? rdy_rnd : rdy_main;

    m_upsample #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .n1         (n1),
        .n2         (n2),
        .n3         (n3),
        .zero_stuff (zero_stuff),
        .io_bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    logic pend_lat   = 1'b0;
    logic prev_stall = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            pend_lat   = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (pend_lat) begin
                chk("latency_valid", {31'd0, bus.o_tvalid}, 32'd1);
            end
            if (prev_stall) begin
                chk("stall_hold_valid", {31'd0, bus.o_tvalid}, 32'd1);
            end
            if (bus.o_tvalid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_beat", bus.o_tdata, 32'hDEAD_BEEF);
                end else begin
                    chk("o_tdata", bus.o_tdata, sb[0].d);
                    chk("o_tlast", {31'd0, bus.o_tlast}, {31'd0, sb[0].l});
                    chk("i_tready_busy", {31'd0, bus.i_tready},
                        {31'd0, sb[0].f & bus.o_tready});
                    if (bus.o_tready) begin
                        $display("beat %0d: data=%h last=%0b", beats, bus.o_tdata, bus.o_tlast);
                        void'(sb.pop_front());
                        beats++;
                    end
                end
            end else begin
                chk("i_tready_idle", {31'd0, bus.i_tready}, 32'd1);
            end
            prev_stall = bus.o_tvalid & ~bus.o_tready;
            pend_lat   = bus.i_tvalid & bus.i_tready;
        end
    end

    // Random backpressure source, used only while rnd_mode is set.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            rdy_rnd = 1'($urandom_range(0, 1));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic push_exp(input logic [31:0] d, input logic l, input int reps);
        exp_t e;
        for (int k = 0; k < reps; k++) begin
            e.d = (k == 0 || !zero_stuff) ? d : 32'h0;
            e.l = l && (k == reps - 1);
            e.f = (k == reps - 1);
            sb.push_back(e);
        end
    endtask

    task automatic send(input logic [31:0] d, input logic l, input int reps, output int waits);
        push_exp(d, l, reps);
        bus.i_tdata  = d;
        bus.i_tlast  = l;
        bus.i_tvalid = 1'b1;
        waits = 0;
        while (1) begin
            @(negedge clk);
            if (bus.i_tready) break;
            waits++;
            if (waits > 500) begin
                chk("accept_timeout", 32'd0, 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.i_tvalid = 1'b0;
        $display("sent %h last=%0b reps=%0d waits=%0d", d, l, reps, waits);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || bus.o_tvalid) && t < 2000) begin
            @(posedge clk);
            t++;
        end
        chk("drain_left", sb.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "global timeout");
    end

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        int w;
        int wsum;
        int b0;
        int t;
        bus.i_tdata  = '0;
        bus.i_tlast  = 1'b0;
        bus.i_tvalid = 1'b0;

        // Reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_o_tvalid", {31'd0, bus.o_tvalid}, 32'd0);
        chk("rst_i_tready", {31'd0, bus.i_tready}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_o_tdata", bus.o_tdata, 32'd0);
        chk("rst_o_tlast", {31'd0, bus.o_tlast}, 32'd0);
        @(posedge clk);
        #1;

        // n1=2 + 1/2: repeat counts 2,3,2,3
        n1 = 16'd2; n2 = 16'd2; n3 = 16'd1;
        b0 = beats;
        send(32'hAAAA_0001, 1'b0, 2, w);
        send(32'hBBBB_0002, 1'b0, 3, w);
        send(32'hCCCC_0003, 1'b0, 2, w);
        send(32'hDDDD_0004, 1'b0, 3, w);
        drain();
        chk("t1_beats", beats - b0, 32'd10);

        // Pass-through n1=0: full throughput, no waits
        n1 = 16'd0; n2 = 16'd0; n3 = 16'd0;
        wsum = 0;
        for (int i = 0; i < 6; i++) begin
            send(32'h1000_0000 + i, (i == 5), 1, w);
            wsum += w;
        end
        drain();
        chk("t2_n1_0_waits", wsum, 32'd0);

        // n1=1, n2=0 behaves the same
        n1 = 16'd1;
        wsum = 0;
        for (int i = 0; i < 6; i++) begin
            send(32'h2000_0000 + i, 1'b0, 1, w);
            wsum += w;
        end
        drain();
        chk("t2_n1_1_waits", wsum, 32'd0);

        // Zero-stuff: data,0,0,0; next sample accepted on the 4th beat
        zero_stuff = 1'b1;
        n1 = 16'd4;
        send(32'h1234_5678, 1'b0, 4, w);
        send(32'hCAFE_F00D, 1'b1, 4, w);
        chk("t3_next_accept_wait", w, 32'd3);
        drain();
        zero_stuff = 1'b0;

        // n1=3, tlast on 2nd sample, random backpressure
        n1 = 16'd3;
        b0 = beats;
        rnd_mode = 1'b1;
        send(32'h3333_0001, 1'b0, 3, w);
        send(32'h3333_0002, 1'b1, 3, w);
        drain();
        rnd_mode = 1'b0;
        chk("t4_beats", beats - b0, 32'd6);

        // Reset mid-burst, with the accumulator left non-zero by sample A
        n1 = 16'd5; n2 = 16'd3; n3 = 16'd2;
        b0 = beats;
        send(32'hAAAA_AAAA, 1'b0, 5, w);
        t = 0;
        while (beats - b0 < 2 && t < 100) begin
            @(posedge clk);
            t++;
        end
        chk("t5_pre_reset_beats", beats - b0, 32'd2);
        #1;
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        chk("t5_rst_o_tvalid", {31'd0, bus.o_tvalid}, 32'd0);
        chk("t5_rst_i_tready", {31'd0, bus.i_tready}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        n2 = 16'd0; n3 = 16'd0;
        b0 = beats;
        send(32'hBBBB_BBBB, 1'b0, 5, w);
        drain();
        chk("t5_b_beats", beats - b0, 32'd5);

        // n1=1 + 2/3 from a cleared accumulator: counts 1,2,2,1,2,2
        n1 = 16'd1; n2 = 16'd3; n3 = 16'd2;
        send(32'h6000_0001, 1'b0, 1, w);
        send(32'h6000_0002, 1'b0, 2, w);
        send(32'h6000_0003, 1'b0, 2, w);
        send(32'h6000_0004, 1'b0, 1, w);
        send(32'h6000_0005, 1'b0, 2, w);
        send(32'h6000_0006, 1'b1, 2, w);
        drain();

        // Misconfiguration n3 >= n2: always extra, accumulator forced to 0
        send(32'h7000_0001, 1'b0, 1, w);       // acc 0 -> 2
        drain();
        n2 = 16'd2; n3 = 16'd3;
        send(32'h7000_0002, 1'b0, 2, w);       // ext, acc -> 0
        send(32'h7000_0003, 1'b0, 2, w);
        drain();
        n2 = 16'd3; n3 = 16'd2;
        send(32'h7000_0004, 1'b1, 1, w);       // 0+2 < 3: no extra
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/m_upsample.md
Name: m_upsample

Overview:
- Fractional interpolator on the MRR gateway AXI-Stream sample path; the transmit-side counterpart of the fractional downsampler.
- Raises the sample rate by n1 + n3/n2. Each accepted input sample is emitted n1 times on the output, plus one extra time whenever a fractional accumulator overflows.
- Optional zero-stuff mode replaces the repeated copies with zeros so a downstream FIR can do proper interpolation.
- Sits between the baseband sample source and the DAC-rate stream.

Parameters:
- WIDTH, 32, sample data width (16-bit I and 16-bit Q packed).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- n1  in  16  integer repeat count; 0 selects pass-through
- n2  in  16  fractional denominator; 0 disables the fractional part
- n3  in  16  fractional numerator; n3 < n2 required
- zero_stuff  in  1  1: repeat copies carry zero data; 0: repeat copies carry the held sample
- i_tdata  in  WIDTH  input sample
- i_tlast  in  1  input end of packet
- i_tvalid  in  1  input valid
- i_tready  out  1  input ready
- o_tdata  out  WIDTH  output sample
- o_tlast  out  1  output end of packet
- o_tvalid  out  1  output valid
- o_tready  in  1  output ready

Behaviour:
- Reset (rst high at a clock edge) clears the following: full=0, o_tvalid=0, o_tdata=0, o_tlast=0, acc=0, remaining=0, first=0. i_tready is forced 0 while rst is high. Reset mid-burst discards the held sample and its outstanding repeats; no output beat is generated for it afterwards.
- Storage is a single holding register (data, last flag, 17-bit remaining counter, first flag). State is EMPTY (full=0) or EMIT (full=1).
- i_tready = ~rst & (~full | (o_tvalid & o_tready & remaining==1)). A new sample can be accepted in the same cycle the last repeat of the previous one is taken, so there are no bubbles.
- On accept (i_tvalid & i_tready):
  - Latch i_tdata and i_tlast; set first=1, full=1.
  - If n1==0: reps=1, acc unchanged.
  - Else compute ext = (n2!=0) & ({1'b0,acc}+n3 >= n2), using a 17-bit sum.
    - If ext: reps = n1+1, acc <= acc+n3-n2.
    - Else: reps = n1, acc <= acc+n3.
  - remaining <= reps (17 bits; maximum 65536).
  - n1/n2/n3 are sampled only at accept. Changing them mid-sample affects only the next sample.
- Misconfiguration n3 >= n2 (with n2 != 0): ext=1 on every sample and acc is forced to 0.
- Latency: o_tvalid rises on the cycle after accept. o_tvalid = full.
- Output data:
  - o_tdata = held data when first=1 or zero_stuff=0.
  - o_tdata = 0 when first=0 and zero_stuff=1.
- Output last: o_tlast = held last & (remaining==1). tlast appears only on the final repeat of a tlast sample.
- On an output beat (o_tvalid & o_tready): first <= 0 and remaining <= remaining-1.
  - If remaining==1 and no simultaneous accept: full <= 0.
  - If remaining==1 with a simultaneous accept: the accept values win.
- When o_tready=0, all held state and outputs stay stable (AXI rule: o_tvalid is never withdrawn and o_tdata never changes while stalled).
- zero_stuff is sampled combinationally. It must be changed only while EMPTY.
- acc never exceeds n2-1 under legal configuration. There is no wrap beyond 16 bits.

Test Plan:
- n1=2, n2=2, n3=1, inputs A,B,C,D, o_tready=1 -> output A,A,B,B,B,C,C,D,D,D (repeat counts 2,3,2,3). i_tready low exactly during the non-final repeats.
- n1=0, continuous valid, o_tready=1 -> one output per input, one-cycle latency, i_tready held 1, full throughput. Same result with n1=1, n2=0.
- zero_stuff=1, n1=4, n2=0, input 0x12345678 -> outputs 0x12345678,0,0,0, then next sample accepted on the 4th beat.
- n1=3, i_tlast=1 on 2nd sample, random o_tready toggling -> o_tlast only on the 6th output beat. o_tdata/o_tvalid stable throughout stalls; beat count 6.
- n1=5, reset asserted after 2 beats of sample A -> o_tvalid=0 and i_tready=0 during reset. After reset, the next input B produces exactly 5 beats of B and no A beats; acc restarts at 0.
- n1=1, n2=3, n3=2, 6 inputs -> repeat counts 1,2,2,1,2,2; acc sequence 2,1,0,2,1,0.
